// File: rtl/mac_pkg.sv
// mac_pkg: shared helpers for the multiply-accumulate slice.
//   acc_width()   - accumulator width: full product plus guard bits
//   sign_extend() - sign-extend the low from_w bits of a MAX_W-wide value
//   sat_max()     - most positive w-bit two's-complement value (zero-extended)
//   sat_min()     - most negative w-bit two's-complement value (sign-extended)
// Callers truncate the MAX_W-wide results to their own width.
package mac_pkg;

  localparam int unsigned MAX_W = 128;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v,
                                                   input int unsigned      from_w);
    logic [MAX_W-1:0] hi;
    hi = '1 << from_w;
    return v[IDX_W'(from_w - 1)] ? (v | hi) : (v & ~hi);
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/mul_BaughWooley.sv
// mul_BaughWooley: combinational signed (two's-complement) multiplier using
// the Baugh-Wooley partial-product array.
//   X - WIDTH-bit signed multiplicand
//   Y - WIDTH-bit signed multiplier
//   P - 2*WIDTH-bit signed product
module mul_BaughWooley #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic [2*WIDTH-1:0] P
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic             pp;

  // Cross terms involving exactly one sign bit are inverted; the resulting
  // offset is corrected by the constant 2^W + 2^(2W-1) (mod 2^(2W)).
  always_comb begin
    sum = '0;
    xs  = '0;
    ys  = '0;
    pp  = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      for (int unsigned j = 0; j < W; j++) begin
        xs = X >> i;
        ys = Y >> j;
        pp = xs[0] & ys[0];
        if ((i == W - 1) != (j == W - 1)) pp = ~pp;
        sum = sum + (PW'(pp) << (i + j));
      end
    end
    sum = sum + (PW'(1) << W) + (PW'(1) << (PW - 1));
    P   = sum;
  end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: pipelined signed multiply-accumulate over frames.
// Operand pairs are registered (S1), multiplied by mul_BaughWooley and the
// sign-extended product registered (S2), then accumulated (S3). The beat
// flagged in_last closes a frame and its sum is presented on out_acc.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - operand handshake; in_x, in_y signed, in_last ends frame
//   out_valid/out_ready  - result handshake
//   out_acc              - ACC_W-bit signed frame sum
//   out_ovf              - signed overflow seen anywhere in the frame
// Build option: define MAC_ACC_SATURATE_EN to clamp the accumulator on
// overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int ACC_GUARD = 8,
  localparam int ACC_W     = acc_width(WIDTH, ACC_GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  logic               stall;
  logic               s1_valid;
  logic               s1_last;
  logic [WIDTH-1:0]   s1_x;
  logic [WIDTH-1:0]   s1_y;
  logic [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]   p_ext;
  logic               s2_valid;
  logic               s2_last;
  logic [ACC_W-1:0]   s2_p;
  logic [ACC_W-1:0]   acc;
  logic               ovf_sticky;
  logic [ACC_W-1:0]   sum_wrap;
  logic [ACC_W-1:0]   sum;
  logic               ovf_now;

  // A held result blocks the whole pipeline so nothing is lost or duplicated.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  mul_BaughWooley #(.WIDTH(WIDTH)) u_mul (
    .X (s1_x),
    .Y (s1_y),
    .P (prod)
  );

  always_comb begin
    p_ext = ACC_W'(sign_extend(MAX_W'(prod), 2 * WIDTH));
  end

  always_comb begin
    sum_wrap = acc + s2_p;
    ovf_now  = (acc[ACC_W-1] == s2_p[ACC_W-1]) &&
               (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_ACC_SATURATE_EN
    if (ovf_now)
      sum = acc[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
    else
      sum = sum_wrap;
`else
    sum = sum_wrap;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_p       <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= in_x;
        s1_y    <= in_y;
        s1_last <= in_last;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p    <= p_ext;
        s2_last <= s1_last;
      end

      // Not stalled means any presented result is being taken this edge,
      // so a closing beat may reload the output back-to-back.
      if (s2_valid && s2_last) begin
        out_acc    <= sum;
        out_ovf    <= ovf_sticky | ovf_now;
        out_valid  <= 1'b1;
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (s2_valid) begin
          acc        <= sum;
          ovf_sticky <= ovf_sticky | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for mac_accumulator.
// A second instance with ACC_GUARD=1 exercises the overflow path; its
// expected value follows MAC_ACC_SATURATE_EN.
module tb_mac_accumulator;

  typedef struct {
    logic [39:0] acc;
    logic        ovf;
    int          lat;   // expected cycle of first appearance, -1 = unchecked
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_acc;
  logic        out_ovf;

  logic        g_in_valid;
  logic        g_in_ready;
  logic [15:0] g_in_x;
  logic [15:0] g_in_y;
  logic        g_in_last;
  logic        g_out_valid;
  logic        g_out_ready;
  logic [32:0] g_out_acc;
  logic        g_out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  mac_accumulator #(.WIDTH(16), .ACC_GUARD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  mac_accumulator #(.WIDTH(16), .ACC_GUARD(1)) dut_g (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (g_in_valid),
    .in_ready  (g_in_ready),
    .in_x      (g_in_x),
    .in_y      (g_in_y),
    .in_last   (g_in_last),
    .out_valid (g_out_valid),
    .out_ready (g_out_ready),
    .out_acc   (g_out_acc),
    .out_ovf   (g_out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int x, input int y, input logic last,
                      input longint exp_acc, input logic exp_ovf, input logic chk_lat);
    exp_t e;
    int   n = 0;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_last  = last;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    if (last) begin
      e.acc = 40'(exp_acc);
      e.ovf = exp_ovf;
      e.lat = chk_lat ? cyc + 3 : -1;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: checks arrival cycle of each new result and its
  // value when the handshake completes.
  logic prev_v  = 1'b0;
  logic prev_hs = 1'b0;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got acc %0h want no output", out_acc);
        end else begin
          if ((!prev_v || prev_hs) && exp_q[0].lat >= 0)
            chk("latency", 64'(cyc), 64'(exp_q[0].lat));
          if (out_ready) begin
            m_e = exp_q.pop_front();
            chk("out_acc", 64'(out_acc), 64'(m_e.acc));
            chk("out_ovf", 64'(out_ovf), 64'(m_e.ovf));
          end
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid & out_ready;
    end
  end

  initial begin
    logic [32:0] g_exp;
    int          n;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_x        = '0;
    in_y        = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    g_in_valid  = 1'b0;
    g_in_x      = '0;
    g_in_y      = '0;
    g_in_last   = 1'b0;
    g_out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_acc", 64'(out_acc), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_g_in_ready", 64'(g_in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Two-beat frame: 3*4 + (-2)*5 = 2
    beat(3, 4, 1'b0, 0, 1'b0, 1'b0);
    beat(-2, 5, 1'b1, 2, 1'b0, 1'b1);
    idle();
    repeat (4) tick();

    // Most negative operands, single beat
    beat(-32768, -32768, 1'b1, 1073741824, 1'b0, 1'b1);
    idle();
    repeat (4) tick();

    // Backpressure: two frames queue up behind a held result
    out_ready = 1'b0;
    beat(1, 1, 1'b1, 1, 1'b0, 1'b1);
    beat(2, 2, 1'b1, 4, 1'b0, 1'b0);
    idle();
    repeat (3) tick();
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_acc", 64'(out_acc), 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    chk("stall_hold_acc", 64'(out_acc), 64'd1);
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset mid-frame discards partial sum
    beat(100, 100, 1'b0, 0, 1'b0, 1'b0);
    beat(50, 50, 1'b0, 0, 1'b0, 1'b0);
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_acc", 64'(out_acc), 64'd0);
    chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    beat(7, 7, 1'b1, 49, 1'b0, 1'b1);
    idle();
    repeat (4) tick();

    // Back-to-back single-beat frames
    beat(1, 2, 1'b1, 2, 1'b0, 1'b1);
    beat(3, 4, 1'b1, 12, 1'b0, 1'b1);
    beat(-5, 6, 1'b1, -30, 1'b0, 1'b1);
    idle();
    repeat (5) tick();

    // Narrow accumulator: 4 * 2^30 = 2^32 exceeds 33-bit signed range
`ifdef MAC_ACC_SATURATE_EN
    g_exp = 33'h0_FFFF_FFFF;
`else
    g_exp = 33'h1_0000_0000;
`endif
    g_in_x     = 16'h8000;
    g_in_y     = 16'h8000;
    g_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g_in_last = (i == 3);
      tick();
    end
    g_in_valid = 1'b0;
    g_in_last  = 1'b0;
    n = 0;
    while (!g_out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("g_out_valid", 64'(g_out_valid), 64'd1);
    chk("g_out_acc", 64'(g_out_acc), 64'(g_exp));
    chk("g_out_ovf", 64'(g_out_ovf), 64'd1);
    tick();
    chk("g_out_pulse", 64'(g_out_valid), 64'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Pipelined signed multiply-accumulate stage built around the combinational Baugh-Wooley multiplier (mul_BaughWooley).
- Registers operand pairs, multiplies them, and accumulates products over a frame delimited by in_last.
- Presents one accumulated result per frame on a valid/ready output.
- Sits directly downstream of the operand source and wraps the multiplier, consuming its 2*WIDTH-bit product P.

Parameters:
- WIDTH, 16, operand width; two's-complement signed X and Y.
- ACC_GUARD, 8, guard bits above the 2*WIDTH product. Accumulator width ACC_W = 2*WIDTH+ACC_GUARD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_x  input  WIDTH  signed multiplicand.
- in_y  input  WIDTH  signed multiplier.
- in_last  input  1  final pair of the current frame.
- out_valid  output  1  accumulated result valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed frame sum.
- out_ovf  output  1  signed overflow occurred during the frame.

Behaviour:
- Reset is asynchronous and active-low. Reset clears all pipeline valids, the accumulator, the overflow sticky bit, out_valid, out_acc and out_ovf. Any partial frame is discarded.
- Stall signal: stall = out_valid & ~out_ready. in_ready = ~stall, combinational. in_ready is 1 out of reset.
- A beat is accepted when in_valid & in_ready are high at a rising edge.
- S1 (edge k): register x, y, last and valid. S1 drives mul_BaughWooley combinationally.
- S2 (edge k+1): register P sign-extended to ACC_W, plus last and valid.
- S3 (edge k+2), when S2 valid:
  - sum = acc + p_ext, with signed overflow detection.
  - If S2 last: out_acc <= sum, out_ovf <= ovf_sticky | ovf_now, out_valid <= 1, acc <= 0, ovf_sticky <= 0.
  - Otherwise: acc <= sum, ovf_sticky |= ovf_now.
- Latency: out_valid rises 2 edges after the acceptance edge of the last beat. Throughput is 1 beat per cycle.
- While stall is high, S1, S2, acc and the out registers all hold. No beat is lost or duplicated.
- Output handshake:
  - out_valid & out_ready with no new last result in S3: out_valid <= 0, and out_acc/out_ovf hold their values.
  - Handshake and a last beat in S3 in the same cycle: the output register reloads and out_valid stays 1. Back-to-back frames are supported.
- A single-beat frame (in_last on the first beat) outputs that product.
- Beats before a frame's first last belong to that frame. There is no frame-length limit; wrap or saturate governs overflow.
- Overflow: ovf_now when the operand signs match and the result sign differs. Without SATURATE_EN the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro: MAC_ACC_SATURATE_EN.
- Defined: on overflow, sum clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the operand sign. The overflow flag is still set. Later additions continue from the clamped value.
- Undefined: two's-complement wrap; overflow is only flagged.

Decomposition:
- Package mac_pkg holds:
  - the ACC_W derivation function;
  - the sign-extend helper;
  - the saturation limit constants as functions of ACC_W.
- Sub-module: one instance of the existing mul_BaughWooley with WIDTH passed through. The remaining pipeline, accumulator and handshake logic stay in mac_accumulator.

Test Plan:
- WIDTH=16, out_ready=1: beats (3,4), (-2,5,last) -> one out_valid pulse, out_acc=2, out_ovf=0, 2 edges after the last acceptance.
- Single beat (-32768,-32768,last) -> out_acc=1073741824, out_ovf=0.
- out_ready=0 throughout, frames {(1,1,last)} then {(2,2,last)} -> out_acc=1 held, in_ready drops, second frame stalls in pipeline. Raise out_ready -> out_acc=1, then next cycle out_acc=4, no loss or duplication.
- ACC_GUARD=1 (ACC_W=33), four beats (-32768,-32768), last on the 4th -> wrap: out_acc=-4294967296, out_ovf=1. With MAC_ACC_SATURATE_EN: out_acc=4294967295, out_ovf=1.
- Beats (100,100), (50,50) without last, pulse rst_n low mid-frame, then (7,7,last) -> outputs low during reset, then out_acc=49.
- Back-to-back single-beat frames (1,2), (3,4), (-5,6), each last, every cycle, out_ready=1 -> out_acc sequence 2, 12, -30 on consecutive cycles, out_valid continuously 1.
